// File: rtl/mult_sched_pkg.sv
// Shared types and helpers for the mult_sched scheduler.
package mult_sched_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned N_REQ_DEF = 4;

    // Requester ID width for a given requester count (N_REQ >= 2).
    function automatic int unsigned id_width(input int unsigned n);
        return $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLaunch = 2'd1,
        StRun    = 2'd2,
        StResp   = 2'd3
    } state_e;

endpackage

// File: rtl/mult_sched_if.sv
// Requester and response channels between the clients and mult_sched.
interface mult_sched_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDW   = 2
) ();

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_m;
    logic [N_REQ*WIDTH-1:0] req_n;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [WIDTH-1:0]       rsp_prod;
    logic                   rsp_err;

    // Client side.
    modport master (
        output req_valid, req_m, req_n, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_m, req_n, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err
    );

endinterface

// File: rtl/mult_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request above ptr_i, wrapping to 0.
module mult_sched_rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDW-1:0]   grant_id_o,
    output logic             any_o
);

    // Two passes: requesters above the pointer first, then the wrapped range.
    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        any_o      = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (!any_o && req_i[i] && (i > int'(ptr_i))) begin
                any_o      = 1'b1;
                grant_o[i] = 1'b1;
                grant_id_o = IDW'(i);
            end
        end
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (!any_o && req_i[i] && (i <= int'(ptr_i))) begin
                any_o      = 1'b1;
                grant_o[i] = 1'b1;
                grant_id_o = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one sequential multiplier among N_REQ clients.
// Optional watchdog: define MULT_SCHED_TMO_EN to abort stuck jobs with rsp_err.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int unsigned N_REQ      = N_REQ_DEF,
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned IDW        = id_width(N_REQ),
    parameter int unsigned START_MAX  = 4,
    parameter int unsigned TMO_CYCLES = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mult_sched_if.slave      bus_io,
    output logic             mult_start_o,
    output logic [WIDTH-1:0] mult_m_o,
    output logic [WIDTH-1:0] mult_n_o,
    input  logic [WIDTH-1:0] mult_prod_i,
    input  logic             mult_busy_i
);

    localparam int unsigned SCW = $clog2(START_MAX + 1);

    if (START_MAX < 1 || TMO_CYCLES < 1 || N_REQ < 2 || N_REQ > 8) begin : g_cfg_err
        $error("mult_sched: unsupported parameter set");
    end

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] m_q, m_d, n_q, n_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic [SCW-1:0]   scnt_q, scnt_d;

    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_id;
    logic             grant_any;

`ifdef MULT_SCHED_TMO_EN
    localparam int unsigned TW = $clog2(TMO_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
`endif

    mult_sched_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req_i      (bus_io.req_valid),
        .ptr_i      (ptr_q),
        .grant_o    (grant),
        .grant_id_o (grant_id),
        .any_o      (grant_any)
    );

    // Next-state and handshake outputs for the single in-flight job.
    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        id_d             = id_q;
        m_d              = m_q;
        n_d              = n_q;
        prod_d           = prod_q;
        scnt_d           = scnt_q;
        bus_io.req_ready = '0;
        mult_start_o     = 1'b0;
`ifdef MULT_SCHED_TMO_EN
        tmo_d            = tmo_q;
        err_d            = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                bus_io.req_ready = grant;
                if (grant_any) begin
                    for (int i = 0; i < int'(N_REQ); i++) begin
                        if (grant[i]) begin
                            m_d = bus_io.req_m[i*WIDTH +: WIDTH];
                            n_d = bus_io.req_n[i*WIDTH +: WIDTH];
                        end
                    end
                    ptr_d   = grant_id;
                    id_d    = grant_id;
                    scnt_d  = '0;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                mult_start_o = 1'b1;
                // Give up on seeing busy after START_MAX cycles; RUN then completes at once.
                if (mult_busy_i || (scnt_q == SCW'(START_MAX - 1))) begin
                    state_d = StRun;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            StRun: begin
                if (!mult_busy_i) begin
                    prod_d  = mult_prod_i;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus_io.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef MULT_SCHED_TMO_EN
        // Watchdog spans LAUNCH+RUN and overrides a same-cycle normal completion.
        if (state_q == StLaunch || state_q == StRun) begin
            if (tmo_q == TW'(TMO_CYCLES - 1)) begin
                state_d = StResp;
                err_d   = 1'b1;
                prod_d  = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
        if (state_q == StIdle) begin
            err_d = 1'b0;
        end
`endif
    end

    // State registers; the multiplier itself is not reset, only this FSM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= IDW'(N_REQ - 1);
            id_q    <= '0;
            m_q     <= '0;
            n_q     <= '0;
            prod_q  <= '0;
            scnt_q  <= '0;
`ifdef MULT_SCHED_TMO_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            m_q     <= m_d;
            n_q     <= n_d;
            prod_q  <= prod_d;
            scnt_q  <= scnt_d;
`ifdef MULT_SCHED_TMO_EN
            tmo_q   <= tmo_d;
            err_q   <= err_d;
`endif
        end
    end

    assign mult_m_o        = m_q;
    assign mult_n_o        = n_q;
    assign bus_io.rsp_valid = (state_q == StResp);
    assign bus_io.rsp_id    = id_q;
    assign bus_io.rsp_prod  = prod_q;
`ifdef MULT_SCHED_TMO_EN
    assign bus_io.rsp_err   = err_q;
`else
    assign bus_io.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched with a behavioural multiplier and scheduler model.
module tb_mult_sched;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int HIGH = 8;
    localparam int TMO  = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mult_start;
    logic         mult_busy = 1'b0;
    logic [W-1:0] mult_m, mult_n;
    logic [W-1:0] mult_prod = '0;

    mult_sched_if #(.N_REQ(N), .WIDTH(W), .IDW(2)) bus ();

    mult_sched #(
        .N_REQ      (N),
        .WIDTH      (W),
        .IDW        (2),
        .START_MAX  (4),
        .TMO_CYCLES (TMO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus_io       (bus.slave),
        .mult_start_o (mult_start),
        .mult_m_o     (mult_m),
        .mult_n_o     (mult_n),
        .mult_prod_i  (mult_prod),
        .mult_busy_i  (mult_busy)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Multiplier model: busy rises the cycle after start, stays HIGH cycles.
    // mmode 0 = normal, 1 = never raises busy, 2 = busy stuck high.
    int mmode = 0;
    bit mclr = 0;
    int hcnt = 0;

    function automatic logic [15:0] mul16(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = {16'h0, a} * {16'h0, b};
        return p[15:0];
    endfunction

    always @(posedge clk) begin
        if (mclr) begin
            mult_busy <= 1'b0;
        end else if (mult_busy) begin
            if (mmode != 2) begin
                if (hcnt == 0) mult_busy <= 1'b0;
                else hcnt <= hcnt - 1;
            end
        end else if (mult_start) begin
            mult_prod <= mul16(mult_m, mult_n);
            if (mmode != 1) begin
                mult_busy <= 1'b1;
                hcnt      <= HIGH - 1;
            end
        end
    end

    // Scheduler model: round-robin grant when no job outstanding, FIFO of expected responses.
    typedef struct {
        int id;
        int prod;
        bit err;
    } rsp_t;

    rsp_t expq[$];
    int   mptr = N - 1;
    bit   mjob = 0;
    bit   exp_tmo = 0;
    int   g_cyc = 0;
    int   hs_cnt = 0;
    int   st_rises = 0;
    int   st_cycles = 0;
    logic start_prev = 1'b0;

    always @(negedge clk) begin : model
        logic [N-1:0] exp_rdy;
        int           gid;
        bit           job_now;
        rsp_t         e;
        if (rst) begin
            mjob = 0;
            mptr = N - 1;
            expq.delete();
            start_prev = 1'b0;
        end else begin
            if (mult_start && !start_prev) st_rises++;
            if (mult_start) st_cycles++;
            start_prev = mult_start;
            job_now = mjob;
            exp_rdy = '0;
            gid = -1;
            if (!job_now) begin
                for (int k = 1; k <= N; k++) begin
                    if (gid < 0 && bus.req_valid[(mptr + k) % N]) gid = (mptr + k) % N;
                end
            end
            if (gid >= 0) exp_rdy[gid] = 1'b1;
            chk("req_ready", bus.req_ready, exp_rdy);
            if (bus.rsp_valid) begin
                if (expq.size() == 0) begin
                    chk("rsp_unexpected", bus.rsp_valid, 0);
                end else begin
                    chk("rsp_id", bus.rsp_id, expq[0].id);
                    chk("rsp_prod", bus.rsp_prod, expq[0].prod);
                    chk("rsp_err", bus.rsp_err, expq[0].err);
                    if (bus.rsp_ready) begin
                        void'(expq.pop_front());
                        mjob = 0;
                        hs_cnt++;
                    end
                end
            end
            if (gid >= 0) begin
                mjob  = 1;
                mptr  = gid;
                g_cyc = cyc;
                e.id  = gid;
                e.err = exp_tmo;
                e.prod = exp_tmo ? 0 :
                    int'((longint'(bus.req_m[gid*W +: W]) * longint'(bus.req_n[gid*W +: W]))
                         % 65536);
                expq.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] m, input logic [15:0] n);
        bus.req_m[i*W +: W] = m;
        bus.req_n[i*W +: W] = n;
    endtask

    task automatic wait_rsp(input int budget, output bit got, output int lat,
                            output logic [1:0] id, output logic [15:0] prod, output logic err);
        got = 0;
        lat = -1;
        id = '0;
        prod = '0;
        err = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                got  = 1;
                lat  = cyc - g_cyc;
                id   = bus.rsp_id;
                prod = bus.rsp_prod;
                err  = bus.rsp_err;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        bit          got;
        int          lat;
        int          hs0;
        logic [1:0]  id;
        logic [15:0] prod;
        logic        err;
        int          ids[5];
        int          prods[5];
        int          exp_ids[5];
        int          exp_prods[5];
        exp_ids   = '{0, 1, 2, 3, 0};
        exp_prods = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0010};

        bus.req_valid = '0;
        bus.req_m     = '0;
        bus.req_n     = '0;
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        repeat (3) step();

        // Reset state
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_prod", bus.rsp_prod, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_mult_start", mult_start, 0);
        chk("rst_mult_m", mult_m, 0);
        chk("rst_mult_n", mult_n, 0);
        rst = 1'b0;

        // Single request from requester 0
        set_op(0, 16'h00AB, 16'h00CD);
        st_rises = 0;
        st_cycles = 0;
        bus.req_valid = 4'b0001;
        step();
        bus.req_valid = '0;
        wait_rsp(40, got, lat, id, prod, err);
        chk("t1_got", got, 1);
        chk("t1_latency", lat, 11);
        chk("t1_id", id, 0);
        chk("t1_prod", prod, 16'h88EF);
        chk("t1_err", err, 0);
        step();
        chk("t1_rsp_drop", bus.rsp_valid, 0);
        chk("t1_start_pulses", st_rises, 1);
        chk("t1_start_cycles", st_cycles, 2);

        // Fairness with all requesters valid, starting from reset priority
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_op(i, 16'(i + 1), 16'h0010);
        bus.req_valid = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_rsp(40, got, lat, id, prod, err);
            chk("t2_got", got, 1);
            ids[j]   = int'(id);
            prods[j] = int'(prod);
        end
        step();
        bus.req_valid = '0;
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("t2_id%0d", j), ids[j], exp_ids[j]);
            chk($sformatf("t2_prod%0d", j), prods[j], exp_prods[j]);
        end

        // Backpressure: response held 5 cycles while requester 3 waits
        bus.rsp_ready = 1'b0;
        set_op(2, 16'h1234, 16'h0002);
        set_op(3, 16'h0011, 16'h0011);
        bus.req_valid = 4'b1100;
        step();
        bus.req_valid = 4'b1000;
        wait_rsp(40, got, lat, id, prod, err);
        chk("t3_got", got, 1);
        chk("t3_id", id, 2);
        chk("t3_prod", prod, 16'h2468);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_hold_valid", bus.rsp_valid, 1);
            chk("t3_hold_id", bus.rsp_id, 2);
            chk("t3_hold_prod", bus.rsp_prod, 16'h2468);
        end
        hs0 = hs_cnt;
        step();
        bus.rsp_ready = 1'b1;
        step();
        chk("t3_one_rsp", hs_cnt, hs0 + 1);
        wait_rsp(40, got, lat, id, prod, err);
        step();
        bus.req_valid = '0;
        chk("t3b_got", got, 1);
        chk("t3b_id", id, 3);
        chk("t3b_prod", prod, 16'h0121);

        // Reset while the multiplier is running
        set_op(0, 16'h0007, 16'h0009);
        bus.req_valid = 4'b0001;
        step();
        bus.req_valid = '0;
        repeat (4) step();
        rst = 1'b1;
        step();
        chk("t4_rst_req_ready", bus.req_ready, 0);
        chk("t4_rst_rsp_valid", bus.rsp_valid, 0);
        chk("t4_rst_rsp_id", bus.rsp_id, 0);
        chk("t4_rst_rsp_prod", bus.rsp_prod, 0);
        chk("t4_rst_rsp_err", bus.rsp_err, 0);
        chk("t4_rst_mult_start", mult_start, 0);
        chk("t4_rst_mult_m", mult_m, 0);
        chk("t4_rst_mult_n", mult_n, 0);
        rst = 1'b0;
        for (int k = 0; k < 40 && mult_busy; k++) step();
        set_op(0, 16'h0003, 16'h0005);
        bus.req_valid = 4'b0001;
        step();
        bus.req_valid = '0;
        wait_rsp(40, got, lat, id, prod, err);
        chk("t4_got", got, 1);
        chk("t4_latency", lat, 11);
        chk("t4_id", id, 0);
        chk("t4_prod", prod, 16'h000F);
        step();

        // Multiplier never raises busy: start held START_MAX cycles, product truncated
        mmode = 1;
        st_rises = 0;
        st_cycles = 0;
        set_op(1, 16'h0102, 16'h0304);
        bus.req_valid = 4'b0010;
        step();
        bus.req_valid = '0;
        wait_rsp(40, got, lat, id, prod, err);
        chk("t5_got", got, 1);
        chk("t5_latency", lat, 6);
        chk("t5_id", id, 1);
        chk("t5_prod", prod, 16'h0A08);
        step();
        chk("t5_start_cycles", st_cycles, 4);
        chk("t5_start_pulses", st_rises, 1);
        mmode = 0;

        // Busy stuck high
        mmode = 2;
        set_op(2, 16'h0005, 16'h0005);
`ifdef MULT_SCHED_TMO_EN
        exp_tmo = 1'b1;
        bus.req_valid = 4'b0100;
        step();
        bus.req_valid = '0;
        wait_rsp(TMO + 20, got, lat, id, prod, err);
        chk("t6_got", got, 1);
        chk("t6_id", id, 2);
        chk("t6_prod", prod, 0);
        chk("t6_err", err, 1);
        step();
        exp_tmo = 1'b0;
`else
        bus.req_valid = 4'b0100;
        step();
        bus.req_valid = '0;
        wait_rsp(TMO + 40, got, lat, id, prod, err);
        chk("t6_no_rsp", got, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
`endif
        mclr = 1'b1;
        step();
        mclr = 1'b0;
        mmode = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mult_sched.md
Name: mult_sched

Overview:
- Round-robin scheduler sharing one sequential 16-bit `mult` unit (start/busy/prod interface) between N_REQ requesters.
- Accepts one operand pair at a time from the requesters.
- Sequences the multiplier's start/busy handshake, then returns the product tagged with the requester ID on a shared response channel with backpressure.
- Sits between the mult datapath and the client blocks.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 16, operand/product width; must match the mult unit.
- IDW, 2, requester ID width; equals clog2(N_REQ).
- START_MAX, 4, maximum cycles start is held while waiting for busy to rise.
- TMO_CYCLES, 64, watchdog limit in cycles (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept; one-hot or zero
- req_m  in  N_REQ*WIDTH  operand m; requester i occupies bits [i*WIDTH +: WIDTH]
- req_n  in  N_REQ*WIDTH  operand n, same packing as req_m
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  requester ID of the response
- rsp_prod  out  WIDTH  product (low WIDTH bits, as produced by mult)
- rsp_err  out  1  timeout flag; tied 0 without the optional feature
- mult_start  out  1  drives mult start
- mult_m  out  WIDTH  drives mult m_in
- mult_n  out  WIDTH  drives mult n_in
- mult_prod  in  WIDTH  from mult prod
- mult_busy  in  1  from mult busy

Behaviour:
- Reset: all outputs 0, FSM in IDLE, RR pointer = N_REQ-1 (requester 0 has first priority). A reset mid-operation abandons the job with no response. The mult unit is not reset; the FSM re-enters IDLE.
- FSM states: IDLE, LAUNCH, RUN, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching upward from pointer+1 (wrapping).
  - req_ready[g] = 1 for exactly that cycle; the transfer completes in that cycle.
  - Latch m, n, and g; update pointer := g; go to LAUNCH.
  - req_ready is combinational from req_valid and the pointer, and only nonzero in IDLE.
- LAUNCH:
  - mult_start = 1; mult_m/mult_n hold the latched operands (held stable through RUN).
  - Stay until mult_busy = 1 is sampled, or START_MAX cycles elapse, then go to RUN with mult_start = 0.
  - If START_MAX expires without busy, RUN sees busy=0 and completes next cycle.
- RUN: wait for mult_busy = 0, then capture mult_prod into rsp_prod and go to RESP.
- RESP:
  - rsp_valid = 1; rsp_id, rsp_prod, and rsp_err are held stable until rsp_valid && rsp_ready.
  - On handshake, return to IDLE.
  - No new grant is issued in the handshake cycle; minimum request-to-request spacing is 1 idle cycle.
- Latency: grant → rsp_valid = 1 (launch) + busy-rise cycles + busy-high cycles + 1.
- Only one job is in flight; other requesters see req_ready = 0 while the FSM is not IDLE.
- A requester may drop req_valid before grant without side effect.
- Fairness: with all requesters continuously valid, grants follow 0,1,2,3,0…
- Products are truncated to WIDTH exactly as mult produces them; no extension.

Optional Feature:
- Macro: MULT_SCHED_TMO_EN.
- Defined:
  - A counter runs in LAUNCH+RUN.
  - Reaching TMO_CYCLES without busy falling forces RESP with rsp_err = 1 and rsp_prod = 0.
  - mult_start is deasserted.
- Undefined: no counter; rsp_err is constant 0; RUN waits indefinitely.

Decomposition:
- Shared package mult_pkg:
  - state encoding constants (IDLE=0, LAUNCH=1, RUN=2, RESP=3)
  - WIDTH default
  - IDW width function/constant
- One sub-module, rr_arbiter:
  - inputs req[N_REQ], ptr[IDW]
  - outputs grant one-hot, grant_id, any
  - purely combinational; the pointer register lives in mult_sched.

Test Plan:
- Single request: req_valid=0001, m=0x00AB, n=0x00CD; bench mult model raises busy 1 cycle after start and holds it 8 cycles → one start pulse, rsp_valid with rsp_id=0, rsp_prod=0x88EF, rsp_err=0.
- All four requesters valid continuously, operands (i+1, 0x0010) → responses in ID order 0,1,2,3,0, products 0x0010, 0x0020, 0x0030, 0x0040.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_id/rsp_prod stable, no req_ready pulses, exactly one response after rsp_ready=1.
- Reset asserted during RUN → next cycle all outputs 0 and FSM in IDLE; next request (0x0003 × 0x0005) returns 0x000F.
- Model never raises busy → start held exactly START_MAX=4 cycles, response with product sampled from mult_prod.
- With MULT_SCHED_TMO_EN: busy stuck high → after 64 cycles rsp_valid=1, rsp_err=1, rsp_prod=0; without the macro, no response is issued.
